// File: rtl/spi_pkg.sv
// Shared definitions for the SPI configuration sequencer: command fields, table entry
// type, FSM state type and the default configuration table.
package spi_pkg;

    localparam int unsigned MaxCmds = 16;
    localparam int unsigned FieldW  = 16; // widest cmd/exp field a table entry can carry

    // Field layout of the default 12-bit command word
    localparam int unsigned WrBit  = 11;
    localparam int unsigned AddrHi = 10;
    localparam int unsigned AddrLo = 8;
    localparam int unsigned DataHi = 7;
    localparam int unsigned DataLo = 0;

    typedef struct packed {
        logic [FieldW-1:0] cmd;
        logic [FieldW-1:0] exp;
        logic              chk;
    } cfg_entry_t;

    typedef cfg_entry_t [MaxCmds-1:0] cfg_table_t;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StRdWait,
        StGap,
        StDone
    } seq_state_e;

    function automatic cfg_entry_t mk_entry(input logic       wr,
                                            input logic [2:0] addr,
                                            input logic [7:0] data,
                                            input logic [7:0] exp,
                                            input logic       chk);
        cfg_entry_t e;
        e                    = '0;
        e.cmd[WrBit]         = wr;
        e.cmd[AddrHi:AddrLo] = addr;
        e.cmd[DataHi:DataLo] = data;
        e.exp[7:0]           = exp;
        e.chk                = chk;
        return e;
    endfunction

    function automatic cfg_table_t default_table();
        cfg_table_t t;
        t     = '0;
        t[0]  = mk_entry(1'b1, 3'd0, 8'hA5, 8'h00, 1'b0);
        t[1]  = mk_entry(1'b1, 3'd1, 8'h12, 8'h00, 1'b0);
        t[2]  = mk_entry(1'b0, 3'd3, 8'h00, 8'h5A, 1'b1);
        t[3]  = mk_entry(1'b1, 3'd2, 8'h3C, 8'h00, 1'b0);
        t[4]  = mk_entry(1'b1, 3'd4, 8'h81, 8'h00, 1'b0);
        t[5]  = mk_entry(1'b0, 3'd4, 8'h00, 8'h81, 1'b1);
        t[6]  = mk_entry(1'b1, 3'd5, 8'h07, 8'h00, 1'b0);
        t[7]  = mk_entry(1'b1, 3'd6, 8'hF0, 8'h00, 1'b0);
        t[8]  = mk_entry(1'b0, 3'd6, 8'h00, 8'hF0, 1'b1);
        t[9]  = mk_entry(1'b1, 3'd7, 8'h01, 8'h00, 1'b0);
        t[10] = mk_entry(1'b0, 3'd7, 8'h00, 8'h00, 1'b0);
        t[11] = mk_entry(1'b1, 3'd0, 8'h5A, 8'h00, 1'b0);
        t[12] = mk_entry(1'b0, 3'd0, 8'h00, 8'h5A, 1'b1);
        t[13] = mk_entry(1'b1, 3'd1, 8'hC3, 8'h00, 1'b0);
        t[14] = mk_entry(1'b1, 3'd2, 8'h99, 8'h00, 1'b0);
        t[15] = mk_entry(1'b0, 3'd1, 8'h00, 8'hC3, 1'b1);
        return t;
    endfunction

    localparam cfg_table_t DefaultTable = default_table();

endpackage

// File: rtl/spi_cfg_seq.sv
// Walks a constant table of SPI commands: issues each with a valid/ready handshake,
// checks read data against expected values, and spaces commands by a fixed gap.
module spi_cfg_seq
    import spi_pkg::*;
#(
    parameter int unsigned CMD_WIDTH  = 12,
    parameter int unsigned READ_WIDTH = 8,
    parameter int unsigned NUM_CMDS   = 16,
    parameter int unsigned GAP_CYCLES = 100,
    parameter int unsigned RD_TIMEOUT = 1000,
    parameter cfg_table_t  TABLE      = DefaultTable
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [CMD_WIDTH-1:0]  cmd_out,
    output logic                  cmd_vld,
    input  logic                  cmd_rdy,
    input  logic                  read_vld,
    input  logic [READ_WIDTH-1:0] read_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  timeout,
    output logic [3:0]            err_idx
);

    localparam int unsigned CntMax = (GAP_CYCLES > RD_TIMEOUT) ? GAP_CYCLES : RD_TIMEOUT;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] GapLast = CntW'(GAP_CYCLES - 1);
    localparam logic [CntW-1:0] RdLast  = CntW'(RD_TIMEOUT - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [3:0]      IdxLast = 4'(NUM_CMDS - 1);

    seq_state_e           state_q;
    logic [3:0]           idx_q;
    logic [3:0]           idx_nxt;
    logic [CntW-1:0]      cnt_q;
    logic [CMD_WIDTH-1:0] cmd_out_q;
    logic                 cmd_vld_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 err_q;
    logic                 timeout_q;
    logic [3:0]           err_idx_q;
    logic                 rd_mismatch;

    assign idx_nxt     = idx_q + 4'd1;
    assign rd_mismatch = TABLE[idx_q].chk &&
                         (read_data != TABLE[idx_q].exp[READ_WIDTH-1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            cnt_q     <= '0;
            cmd_out_q <= '0;
            cmd_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
            err_idx_q <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q   <= StIssue;
                        idx_q     <= '0;
                        cnt_q     <= '0;
                        cmd_out_q <= TABLE[0].cmd[CMD_WIDTH-1:0];
                        cmd_vld_q <= 1'b1;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        err_q     <= 1'b0;
                        timeout_q <= 1'b0;
                        err_idx_q <= '0;
                    end
                end
                StIssue: begin
                    // cmd_vld_q is always high in this state, so cmd_rdy alone completes it
                    if (cmd_rdy) begin
                        cmd_vld_q <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= cmd_out_q[CMD_WIDTH-1] ? StGap : StRdWait;
                    end
                end
                StRdWait: begin
                    if (read_vld) begin
                        if (rd_mismatch) begin
                            err_q <= 1'b1;
                            if (!err_q) begin
                                err_idx_q <= idx_q;
                            end
                        end
                        cnt_q   <= '0;
                        state_q <= StGap;
                    end else if (cnt_q == RdLast) begin
                        err_q     <= 1'b1;
                        timeout_q <= 1'b1;
                        if (!err_q) begin
                            err_idx_q <= idx_q;
                        end
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
                StGap: begin
                    if (cnt_q == GapLast) begin
                        cnt_q <= '0;
                        if (idx_q == IdxLast) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            idx_q     <= idx_nxt;
                            cmd_out_q <= TABLE[idx_nxt].cmd[CMD_WIDTH-1:0];
                            cmd_vld_q <= 1'b1;
                            state_q   <= StIssue;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign cmd_out = cmd_out_q;
    assign cmd_vld = cmd_vld_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign timeout = timeout_q;
    assign err_idx = err_idx_q;

endmodule

// File: tb/tb_spi_cfg_seq.sv
// Bench for spi_cfg_seq: directed scenarios plus randomised runs scored against a
// table-walking model of expected commands, errors and timing.
module tb_spi_cfg_seq;
    import spi_pkg::*;

    localparam int unsigned Gap  = 8;
    localparam int unsigned RdTo = 40;
    localparam int unsigned NCmd = 8;

    function automatic cfg_table_t tb_table();
        cfg_table_t t;
        t = '0;
        t[0].cmd = 16'h08A5;
        t[1].cmd = 16'h0912;
        t[2].cmd = 16'h0300; t[2].exp = 16'h005A; t[2].chk = 1'b1;
        t[3].cmd = 16'h0300; t[3].exp = 16'h005A; t[3].chk = 1'b1;
        t[4].cmd = 16'h09AB;
        t[5].cmd = 16'h08CD;
        t[6].cmd = 16'h03C0; t[6].exp = 16'h0077; t[6].chk = 1'b1;
        t[7].cmd = 16'h0301;
        return t;
    endfunction

    localparam cfg_table_t TbTable = tb_table();

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [11:0] cmd_out;
    logic        cmd_vld;
    logic        cmd_rdy;
    logic        read_vld;
    logic [7:0]  read_data;
    logic        busy;
    logic        done;
    logic        err;
    logic        timeout;
    logic [3:0]  err_idx;

    always #5 clk = ~clk;

    spi_cfg_seq #(
        .CMD_WIDTH (12),
        .READ_WIDTH(8),
        .NUM_CMDS  (NCmd),
        .GAP_CYCLES(Gap),
        .RD_TIMEOUT(RdTo),
        .TABLE     (TbTable)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .cmd_out  (cmd_out),
        .cmd_vld  (cmd_vld),
        .cmd_rdy  (cmd_rdy),
        .read_vld (read_vld),
        .read_data(read_data),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .timeout  (timeout),
        .err_idx  (err_idx)
    );

    int          checks = 0;
    int          passes = 0;
    int          cyc = 0;
    int          hs_n = 0;
    int          hs_base = 0;
    int          hs_cyc[0:1023];
    logic [11:0] hs_cmd[0:1023];
    int          run_id = 0;
    int          plan_n = 0;
    int          plan_d[0:15];
    logic [7:0]  plan_dat[0:15];
    int          stray_cyc = -1;
    int          rdy_mode = 0;

    // Model outputs
    int          m_n;
    logic [11:0] m_cmd[0:15];
    int          m_delta[0:15];
    bit          m_err;
    bit          m_to;
    int          m_idx;
    int          m_tail;

    // Environment: records handshakes at the edge, then drives cmd_rdy/read_vld mid-cycle.
    initial begin
        int         rd_ptr;
        int         last_run;
        int         resp_cnt;
        logic [7:0] resp_dat;
        rd_ptr = 0; last_run = 0; resp_cnt = -1; resp_dat = 8'h00;
        cmd_rdy = 1'b0; read_vld = 1'b0; read_data = 8'h00;
        forever begin
            @(posedge clk);
            if (last_run != run_id) begin
                rd_ptr = 0; last_run = run_id; resp_cnt = -1;
            end
            if (rst_n === 1'b1 && cmd_vld === 1'b1 && cmd_rdy === 1'b1 && hs_n < 1024) begin
                hs_cyc[hs_n] = cyc;
                hs_cmd[hs_n] = cmd_out;
                hs_n++;
                if (!cmd_out[11]) begin
                    if (rd_ptr < plan_n) begin
                        resp_cnt = plan_d[rd_ptr];
                        resp_dat = plan_dat[rd_ptr];
                    end
                    rd_ptr++;
                end
            end
            cyc++;
            @(negedge clk);
            read_vld  = 1'b0;
            read_data = 8'($urandom);
            if (cyc == stray_cyc) begin
                read_vld = 1'b1; read_data = 8'hFF;
            end else if (resp_cnt == 0) begin
                read_vld = 1'b1; read_data = resp_dat; resp_cnt = -1;
            end else if (resp_cnt > 0) begin
                resp_cnt--;
            end
            case (rdy_mode)
                0:       cmd_rdy = 1'b1;
                1:       cmd_rdy = 1'($urandom_range(0, 1));
                default: cmd_rdy = 1'b0;
            endcase
        end
    end

    task automatic begin_run(input int mode);
        run_id++;
        rdy_mode  = mode;
        hs_base   = hs_n;
        stray_cyc = -1;
    endtask

    // Reads occur at table rows 2, 3, 6, 7 in that order.
    task automatic set_plan(input int d0, input logic [7:0] x0, input int d1, input logic [7:0] x1,
                            input int d2, input logic [7:0] x2, input int d3, input logic [7:0] x3);
        plan_n = 4;
        plan_d[0] = d0; plan_dat[0] = x0;
        plan_d[1] = d1; plan_dat[1] = x1;
        plan_d[2] = d2; plan_dat[2] = x2;
        plan_d[3] = d3; plan_dat[3] = x3;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output bit ok, output int seen_cyc);
        ok = 1'b0; seen_cyc = -1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1; seen_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic wait_hs(input int total, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (hs_n >= total) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Walk the table as a reader would: every row is issued until a read goes unanswered.
    task automatic model_run();
        int rp;
        rp = 0; m_n = 0; m_err = 1'b0; m_to = 1'b0; m_idx = 0; m_tail = 0;
        for (int i = 0; i < int'(NCmd); i++) begin
            m_cmd[m_n] = TbTable[i].cmd[11:0];
            m_n++;
            if (TbTable[i].cmd[11]) begin
                m_delta[m_n-1] = Gap + 1;
                m_tail = Gap;
            end else begin
                int         d;
                logic [7:0] dat;
                d   = (rp < plan_n) ? plan_d[rp] : -1;
                dat = (rp < plan_n) ? plan_dat[rp] : 8'h00;
                rp++;
                if (d < 0 || d >= int'(RdTo)) begin
                    if (!m_err) m_idx = i;
                    m_err = 1'b1; m_to = 1'b1; m_tail = RdTo;
                    break;
                end
                if (TbTable[i].chk && dat != TbTable[i].exp[7:0]) begin
                    if (!m_err) m_idx = i;
                    m_err = 1'b1;
                end
                m_delta[m_n-1] = d + Gap + 2;
                m_tail = d + 1 + Gap;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_vld, cmd_out, busy, done, err, timeout, err_idx} !== '0)
            $display("FAIL reset_outputs: got vld=%b cmd=%h busy=%b done=%b err=%b to=%b idx=%0d want all 0",
                     cmd_vld, cmd_out, busy, done, err, timeout, err_idx);
        else passes++;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if ({busy, cmd_vld, done} !== 3'b000)
            $display("FAIL idle_no_start: got busy=%b vld=%b done=%b want 000", busy, cmd_vld, done);
        else passes++;
    endtask

    task automatic test_reads_ok();
        bit ok; int dc; int last;
        begin_run(0);
        set_plan(19, 8'h5A, 7, 8'h5A, 0, 8'h77, 3, 8'($urandom));
        model_run();
        stray_cyc = cyc + 6;  // lands in the gap after the first write
        pulse_start();
        wait_done(3000, ok, dc);
        checks++;
        if (!ok) $display("FAIL ok_done_wait: got no done want done within bound"); else passes++;
        checks++;
        if (hs_n - hs_base != m_n) $display("FAIL ok_hs_count: got %0d want %0d", hs_n - hs_base, m_n);
        else passes++;
        checks++;
        if (hs_cyc[hs_base+1] - hs_cyc[hs_base] != int'(Gap) + 1)
            $display("FAIL two_writes_spacing: got %0d want %0d",
                     hs_cyc[hs_base+1] - hs_cyc[hs_base], Gap + 1);
        else passes++;
        for (int k = 0; k < m_n && k < hs_n - hs_base; k++) begin
            checks++;
            if (hs_cmd[hs_base+k] !== m_cmd[k])
                $display("FAIL ok_cmd[%0d]: got %h want %h", k, hs_cmd[hs_base+k], m_cmd[k]);
            else passes++;
            if (k + 1 < m_n && k + 1 < hs_n - hs_base) begin
                checks++;
                if (hs_cyc[hs_base+k+1] - hs_cyc[hs_base+k] != m_delta[k])
                    $display("FAIL ok_spacing[%0d]: got %0d want %0d", k,
                             hs_cyc[hs_base+k+1] - hs_cyc[hs_base+k], m_delta[k]);
                else passes++;
            end
        end
        last = hs_cyc[hs_n-1];
        checks++;
        if (dc != last + m_tail + 1) $display("FAIL ok_done_time: got %0d want %0d", dc, last + m_tail + 1);
        else passes++;
        checks++;
        if ({err, timeout, busy} !== 3'b000)
            $display("FAIL ok_flags: got err=%b to=%b busy=%b want 000", err, timeout, busy);
        else passes++;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_mismatch();
        bit ok; int dc;
        begin_run(0);
        set_plan(19, 8'h5A, 19, 8'h5B, 2, 8'h00, 1, 8'h11);
        pulse_start();
        wait_done(3000, ok, dc);
        checks++;
        if (!ok) $display("FAIL mm_done_wait: got no done want done within bound"); else passes++;
        checks++;
        if (hs_n - hs_base != 8) $display("FAIL mm_hs_count: got %0d want 8", hs_n - hs_base);
        else passes++;
        checks++;
        if ({err, timeout, err_idx} !== {1'b1, 1'b0, 4'd3})
            $display("FAIL mm_flags: got err=%b to=%b idx=%0d want err=1 to=0 idx=3", err, timeout, err_idx);
        else passes++;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_timeout();
        bit ok; int dc; int e6;
        // Answer on the last permitted cycle: read wins over the terminal count.
        begin_run(0);
        set_plan(1, 8'h5A, 1, 8'h5A, RdTo - 1, 8'h77, 0, 8'h00);
        pulse_start();
        wait_done(3000, ok, dc);
        checks++;
        if (hs_n - hs_base != 8 || timeout !== 1'b0 || err !== 1'b0)
            $display("FAIL to_boundary: got hs=%0d to=%b err=%b want hs=8 to=0 err=0",
                     hs_n - hs_base, timeout, err);
        else passes++;
        repeat (5) @(negedge clk);
        // No answer at all.
        begin_run(0);
        set_plan(1, 8'h5A, 1, 8'h5A, -1, 8'h00, 0, 8'h00);
        pulse_start();
        wait_hs(hs_base + 7, 3000, ok);
        checks++;
        if (!ok) $display("FAIL to_hs_wait: got %0d handshakes want 7", hs_n - hs_base); else passes++;
        e6 = hs_cyc[hs_n-1];
        for (int i = 0; i < 200 && cyc < e6 + int'(RdTo); i++) @(negedge clk);
        checks++;
        if ({timeout, busy} !== 2'b01)
            $display("FAIL to_early: got to=%b busy=%b want to=0 busy=1", timeout, busy);
        else passes++;
        @(negedge clk);
        checks++;
        if ({timeout, err, err_idx, done, busy} !== {1'b1, 1'b1, 4'd6, 1'b1, 1'b0})
            $display("FAIL to_fire: got to=%b err=%b idx=%0d done=%b busy=%b want 1 1 6 1 0",
                     timeout, err, err_idx, done, busy);
        else passes++;
        begin
            int vld_seen; int done_drop;
            vld_seen = 0; done_drop = 0;
            repeat (30) begin
                @(negedge clk);
                if (cmd_vld !== 1'b0) vld_seen++;
                if (done !== 1'b1) done_drop++;
            end
            checks++;
            if (vld_seen != 0 || done_drop != 0 || hs_n - hs_base != 7)
                $display("FAIL to_quiet: got vld=%0d done_drop=%0d hs=%0d want 0 0 7",
                         vld_seen, done_drop, hs_n - hs_base);
            else passes++;
        end
        // Late answer after an earlier mismatch: first failing index is kept.
        begin_run(0);
        set_plan(1, 8'h5A, 1, 8'h00, RdTo, 8'h77, 0, 8'h00);
        pulse_start();
        wait_done(3000, ok, dc);
        repeat (10) @(negedge clk);
        checks++;
        if ({timeout, err, err_idx} !== {1'b1, 1'b1, 4'd3} || hs_n - hs_base != 7)
            $display("FAIL to_late: got to=%b err=%b idx=%0d hs=%0d want 1 1 3 7",
                     timeout, err, err_idx, hs_n - hs_base);
        else passes++;
    endtask

    task automatic test_stall();
        bit ok; int dc; int bad; logic [11:0] c0;
        begin_run(2);
        set_plan(0, 8'h5A, 0, 8'h5A, 0, 8'h77, 0, 8'h00);
        pulse_start();
        c0 = cmd_out; bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            start = (i == 10 || i == 30);
            if (cmd_vld !== 1'b1 || cmd_out !== c0) bad++;
        end
        start = 1'b0;
        checks++;
        if (bad != 0 || c0 !== 12'h8A5)
            $display("FAIL stall_hold: got unstable=%0d cmd=%h want 0 and 8a5", bad, c0);
        else passes++;
        rdy_mode = 0;
        wait_hs(hs_base + 1, 100, ok);
        checks++;
        if (!ok || cmd_vld !== 1'b0)
            $display("FAIL vld_drop: got hs_ok=%b vld=%b want 1 0", ok, cmd_vld);
        else passes++;
        pulse_start();
        wait_done(3000, ok, dc);
        checks++;
        if (hs_n - hs_base != 8 || hs_cmd[hs_base+1] !== 12'h912 || err !== 1'b0 || done !== 1'b1)
            $display("FAIL busy_start_ignored: got hs=%0d cmd1=%h err=%b done=%b want 8 912 0 1",
                     hs_n - hs_base, hs_cmd[hs_base+1], err, done);
        else passes++;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit ok; int dc; int held;
        begin_run(0);
        set_plan(0, 8'h5A, 0, 8'h5B, 0, 8'h77, 0, 8'h00);
        pulse_start();
        wait_hs(hs_base + 6, 3000, ok);
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, err, err_idx} !== {1'b1, 1'b1, 4'd3})
            $display("FAIL pre_reset: got busy=%b err=%b idx=%0d want 1 1 3", busy, err, err_idx);
        else passes++;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({cmd_vld, cmd_out, busy, done, err, timeout, err_idx} !== '0)
            $display("FAIL mid_reset: got vld=%b cmd=%h busy=%b done=%b err=%b to=%b idx=%0d want all 0",
                     cmd_vld, cmd_out, busy, done, err, timeout, err_idx);
        else passes++;
        @(negedge clk); rst_n = 1'b1;
        held = hs_n;
        repeat (30) @(negedge clk);
        checks++;
        if (hs_n != held || busy !== 1'b0 || cmd_vld !== 1'b0)
            $display("FAIL no_resume: got hs=%0d busy=%b vld=%b want %0d 0 0", hs_n, busy, cmd_vld, held);
        else passes++;
        begin_run(0);
        set_plan(0, 8'h5A, 0, 8'h5A, 0, 8'h77, 0, 8'h00);
        pulse_start();
        wait_done(3000, ok, dc);
        checks++;
        if (hs_n - hs_base != 8 || hs_cmd[hs_base] !== 12'h8A5 || err !== 1'b0)
            $display("FAIL restart_idx0: got hs=%0d cmd0=%h err=%b want 8 8a5 0",
                     hs_n - hs_base, hs_cmd[hs_base], err);
        else passes++;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_random();
        bit ok; int dc;
        for (int r = 0; r < 8; r++) begin
            begin_run(1);
            plan_n = 4;
            for (int p = 0; p < 4; p++) begin
                int row;
                row = (p < 2) ? p + 2 : p + 4;
                case ($urandom_range(0, 9))
                    0:       plan_d[p] = -1;
                    1, 2:    plan_d[p] = int'($urandom_range(RdTo - 2, RdTo + 3));
                    default: plan_d[p] = int'($urandom_range(0, 30));
                endcase
                plan_dat[p] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : TbTable[row].exp[7:0];
            end
            model_run();
            pulse_start();
            wait_done(5000, ok, dc);
            repeat (10) @(negedge clk);
            checks++;
            if (!ok || hs_n - hs_base != m_n)
                $display("FAIL rnd%0d_count: got done=%b hs=%0d want done=1 hs=%0d", r, ok, hs_n - hs_base, m_n);
            else passes++;
            for (int k = 0; k < m_n && k < hs_n - hs_base; k++) begin
                checks++;
                if (hs_cmd[hs_base+k] !== m_cmd[k])
                    $display("FAIL rnd%0d_cmd[%0d]: got %h want %h", r, k, hs_cmd[hs_base+k], m_cmd[k]);
                else passes++;
            end
            checks++;
            if ({err, timeout} !== {m_err, m_to} || (m_err && err_idx !== 4'(m_idx)) || (!m_err && err_idx !== 4'd0))
                $display("FAIL rnd%0d_flags: got err=%b to=%b idx=%0d want err=%b to=%b idx=%0d",
                         r, err, timeout, err_idx, m_err, m_to, m_err ? m_idx : 0);
            else passes++;
        end
    endtask

    initial begin
        start = 1'b0;
        rst_n = 1'b0;
        test_reset();
        test_reads_ok();
        test_mismatch();
        test_timeout();
        test_stall();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
